// File: rtl/m68k_bus_sequencer_pkg.sv
// rtl/m68k_bus_sequencer_pkg.sv - bus state encodings, size/lane constants, strobe lane select
package m68k_bus_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_S7,
        ST_ABORT
    } bus_state_t;

    localparam logic SIZE_WORD  = 1'b1;
    localparam logic LANE_UPPER = 1'b0;
    localparam logic LANE_LOWER = 1'b1;

    // Returns {upper, lower}; a set bit means that data strobe takes part in the cycle.
    function automatic logic [1:0] ds_select(input logic size, input logic a0);
        return {(size == SIZE_WORD) || (a0 == LANE_UPPER),
                (size == SIZE_WORD) || (a0 == LANE_LOWER)};
    endfunction

endpackage

// File: rtl/m68k_bus_sequencer_cpuclk_edge_sync.sv
// rtl/m68k_bus_sequencer_cpuclk_edge_sync.sv - CPUCLK synchroniser with registered rise/fall pulses
module cpuclk_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/m68k_bus_sequencer.sv
// rtl/m68k_bus_sequencer.sv - one 68000 asynchronous bus cycle per host request, S0-S7 tracking
module m68k_bus_sequencer
    import m68k_bus_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int TO_W        = 11
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic CPUCLK,
    input  logic BUS_OK,
    input  logic REQ,
    input  logic REQ_RW,
    input  logic REQ_SIZE,
    input  logic REQ_A0,
    input  logic nDTACK,
    input  logic nBERR,
    output logic BUSY,
    output logic ACK,
    output logic ERR,
    output logic nAS,
    output logic nUDS,
    output logic nLDS,
    output logic RnW,
    output logic DOE,
    output logic LATCH
);

    logic rise, fall;
    logic [SYNC_STAGES-1:0] dtack_sync, berr_sync;
    logic dtack_s, berr_s;

    bus_state_t state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic rw_q, rw_d, size_q, size_d, a0_q, a0_d;
    logic nas_q, nas_d, uds_q, uds_d, lds_q, lds_d;
    logic rnw_q, rnw_d, doe_q, doe_d;
    logic busy_q, busy_d, ack_q, ack_d, err_q, err_d, latch_q, latch_d;
    logic [1:0] ds_sel;

    cpuclk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cpuclk_sync (
        .clk   (CLK),
        .rst_n (nRESET),
        .din   (CPUCLK),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            dtack_sync <= '1;
            berr_sync  <= '1;
        end else begin
            dtack_sync <= {dtack_sync[SYNC_STAGES-2:0], nDTACK};
            berr_sync  <= {berr_sync[SYNC_STAGES-2:0], nBERR};
        end
    end

    assign dtack_s = dtack_sync[SYNC_STAGES-1];
    assign berr_s  = berr_sync[SYNC_STAGES-1];
    assign ds_sel  = ds_select(size_q, a0_q);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b1;
            size_q  <= 1'b0;
            a0_q    <= 1'b0;
            nas_q   <= 1'b1;
            uds_q   <= 1'b1;
            lds_q   <= 1'b1;
            rnw_q   <= 1'b1;
            doe_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            a0_q    <= a0_d;
            nas_q   <= nas_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            rnw_q   <= rnw_d;
            doe_q   <= doe_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        size_d  = size_q;
        a0_d    = a0_q;
        nas_d   = nas_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        rnw_d   = rnw_q;
        doe_d   = doe_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        latch_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // busy_q still high here means this is the ACK cycle; a request now is ignored
                if (REQ && BUS_OK && !busy_q) begin
                    rw_d    = REQ_RW;
                    size_d  = REQ_SIZE;
                    a0_d    = REQ_A0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: if (rise) state_d = ST_S0;
            ST_S0: begin
                if (fall) begin
                    state_d = ST_S1;
                    rnw_d   = rw_q;
                    doe_d   = !rw_q;
                end
            end
            ST_S1: begin
                if (rise) begin
                    state_d = ST_S2;
                    nas_d   = 1'b0;
                    if (rw_q) begin
                        uds_d = !ds_sel[1];
                        lds_d = !ds_sel[0];
                    end
                end
            end
            ST_S2: if (fall) state_d = ST_S3;
            ST_S3: begin
                if (rise) begin
                    state_d = ST_S4;
                    if (!rw_q) begin
                        uds_d = !ds_sel[1];
                        lds_d = !ds_sel[0];
                    end
                end
            end
            ST_S4: begin
                if (fall) begin
                    if (!berr_s || (dtack_s && cnt_q == TO_W'(TIMEOUT - 1))) begin
                        state_d = ST_ABORT;
                        nas_d   = 1'b1;
                        uds_d   = 1'b1;
                        lds_d   = 1'b1;
                    end else if (!dtack_s) begin
                        state_d = ST_S5;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_S5: if (rise) state_d = ST_S6;
            ST_S6: begin
                if (fall) begin
                    state_d = ST_S7;
                    nas_d   = 1'b1;
                    uds_d   = 1'b1;
                    lds_d   = 1'b1;
                    latch_d = rw_q;
                end
            end
            ST_S7, ST_ABORT: begin
                if (rise) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                    err_d   = (state_q == ST_ABORT);
                    doe_d   = 1'b0;
                    rnw_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || ack_d;
    end

    assign BUSY  = busy_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign nAS   = nas_q;
    assign nUDS  = uds_q;
    assign nLDS  = lds_q;
    assign RnW   = rnw_q;
    assign DOE   = doe_q;
    assign LATCH = latch_q;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// tb/tb_m68k_bus_sequencer.sv - directed and randomized bus cycles against a duration-level model
module tb_m68k_bus_sequencer;

    localparam int TO = 8;
    localparam int H  = 6;

    logic CLK, nRESET, CPUCLK, BUS_OK, REQ, REQ_RW, REQ_SIZE, REQ_A0, nDTACK, nBERR;
    logic BUSY, ACK, ERR, nAS, nUDS, nLDS, RnW, DOE, LATCH;

    int errors = 0;
    int checks = 0;

    int epoch = 0, seen_epoch = 0;
    int nas_low, uds_low, lds_low, doe_hi, rnw_lo, latch_cnt, ack_cnt, busy_hi;
    logic err_at_ack, busy_at_ack, busy_after, ack_prev;

    m68k_bus_sequencer #(.SYNC_STAGES(2), .TIMEOUT(TO), .TO_W(4)) dut (
        .CLK(CLK), .nRESET(nRESET), .CPUCLK(CPUCLK), .BUS_OK(BUS_OK), .REQ(REQ),
        .REQ_RW(REQ_RW), .REQ_SIZE(REQ_SIZE), .REQ_A0(REQ_A0), .nDTACK(nDTACK), .nBERR(nBERR),
        .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
        .RnW(RnW), .DOE(DOE), .LATCH(LATCH)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        CPUCLK = 0;
        #3;
        forever #60 CPUCLK = ~CPUCLK;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(posedge CLK) begin
        #2;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            nas_low = 0; uds_low = 0; lds_low = 0; doe_hi = 0; rnw_lo = 0;
            latch_cnt = 0; ack_cnt = 0; busy_hi = 0;
            err_at_ack = 1'bx; busy_at_ack = 1'bx; busy_after = 1'bx; ack_prev = 0;
        end
        if (nAS === 1'b0) nas_low++;
        if (nUDS === 1'b0) uds_low++;
        if (nLDS === 1'b0) lds_low++;
        if (DOE === 1'b1) doe_hi++;
        if (RnW === 1'b0) rnw_lo++;
        if (LATCH === 1'b1) latch_cnt++;
        if (BUSY === 1'b1) busy_hi++;
        if (ack_prev) busy_after = BUSY;
        if (ACK === 1'b1) begin
            ack_cnt++;
            err_at_ack = ERR;
            busy_at_ack = BUSY;
        end
        ack_prev = (ACK === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue_req(input string tag, input logic rw, input logic size, input logic a0);
        REQ = 1; REQ_RW = rw; REQ_SIZE = size; REQ_A0 = a0;
        @(negedge CLK);
        chk({tag, " busy_set"}, BUSY, 1);
        REQ = 0;
    endtask

    task automatic serve(input string tag, input logic rw, input logic size, input logic a0,
                         input int dtack_at, input int berr_at);
        int t, lim, n_as, n_ds, n_doe;
        logic ab, up, lo;
        t = (dtack_at < berr_at) ? dtack_at : berr_at;
        if (t > TO - 1) t = TO - 1;
        ab = (berr_at == t) || (dtack_at != t);
        up = size || !a0;
        lo = size || a0;
        n_as  = H * (ab ? 3 + 2 * t : 5 + 2 * t);
        n_ds  = rw ? n_as : H * (ab ? 1 + 2 * t : 3 + 2 * t);
        n_doe = rw ? 0 : H * (ab ? 5 + 2 * t : 7 + 2 * t);

        lim = 0;
        while (nAS !== 1'b0 && lim < 400) begin
            @(negedge CLK);
            lim++;
        end
        chk({tag, " as_start"}, (lim < 400), 1);
        if (lim >= 400) return;

        @(negedge CPUCLK);
        for (int k = 0; k <= t; k++) begin
            @(posedge CPUCLK);
            nDTACK = (k >= dtack_at) ? 1'b0 : 1'b1;
            nBERR  = (k >= berr_at) ? 1'b0 : 1'b1;
            @(negedge CPUCLK);
        end

        lim = 0;
        while (ack_cnt == 0 && lim < 200) begin
            @(negedge CLK);
            lim++;
        end
        repeat (3) @(negedge CLK);
        nDTACK = 1; nBERR = 1;

        chk({tag, " nas_low"}, nas_low, n_as);
        chk({tag, " uds_low"}, uds_low, up ? n_ds : 0);
        chk({tag, " lds_low"}, lds_low, lo ? n_ds : 0);
        chk({tag, " doe_hi"}, doe_hi, n_doe);
        chk({tag, " rnw_lo"}, rnw_lo, n_doe);
        chk({tag, " latch"}, latch_cnt, (rw && !ab) ? 1 : 0);
        chk({tag, " ack"}, ack_cnt, 1);
        chk({tag, " err"}, err_at_ack, ab);
        chk({tag, " busy_at_ack"}, busy_at_ack, 1);
        chk({tag, " busy_after"}, busy_after, 0);
    endtask

    task automatic txn(input string tag, input logic rw, input logic size, input logic a0,
                       input int dtack_at, input int berr_at);
        epoch++;
        issue_req(tag, rw, size, a0);
        serve(tag, rw, size, a0, dtack_at, berr_at);
    endtask

    initial begin
        int lim;
        nRESET = 0; BUS_OK = 1; REQ = 0; REQ_RW = 1; REQ_SIZE = 0; REQ_A0 = 0;
        nDTACK = 1; nBERR = 1;
        repeat (3) @(negedge CLK);
        chk("rst nAS", nAS, 1);
        chk("rst nUDS", nUDS, 1);
        chk("rst nLDS", nLDS, 1);
        chk("rst RnW", RnW, 1);
        chk("rst DOE", DOE, 0);
        chk("rst BUSY", BUSY, 0);
        chk("rst ACK", ACK, 0);
        chk("rst ERR", ERR, 0);
        chk("rst LATCH", LATCH, 0);
        nRESET = 1;
        repeat (5) @(negedge CLK);

        txn("word_read", 1, 1, 0, 0, 99);
        txn("byte_write_a0", 0, 0, 1, 3, 99);
        txn("berr_dtack", 1, 1, 0, 2, 2);
        txn("timeout", 1, 0, 0, 99, 99);
        txn("timeout_again", 0, 1, 0, 99, 99);

        // reset in the middle of a write cycle
        epoch++;
        issue_req("rst_mid", 0, 1, 0);
        lim = 0;
        while (nAS !== 1'b0 && lim < 400) begin
            @(negedge CLK);
            lim++;
        end
        chk("rst_mid as_start", (lim < 400), 1);
        @(negedge CPUCLK);
        @(posedge CPUCLK);
        nDTACK = 0;
        @(negedge CPUCLK);
        #45;
        chk("rst_mid pre DOE", DOE, 1);
        chk("rst_mid pre nAS", nAS, 0);
        nRESET = 0;
        #1;
        chk("rst_mid nAS", nAS, 1);
        chk("rst_mid nUDS", nUDS, 1);
        chk("rst_mid nLDS", nLDS, 1);
        chk("rst_mid DOE", DOE, 0);
        repeat (20) @(negedge CLK);
        chk("rst_mid no_ack", ack_cnt, 0);
        nDTACK = 1;
        nRESET = 1;
        repeat (5) @(negedge CLK);
        txn("after_rst", 1, 0, 1, 1, 99);

        // request held while bus not owned
        epoch++;
        BUS_OK = 0; REQ = 1; REQ_RW = 1; REQ_SIZE = 1; REQ_A0 = 0;
        repeat (120) @(negedge CLK);
        chk("busok nas_idle", nas_low, 0);
        chk("busok busy_idle", busy_hi, 0);
        BUS_OK = 1;
        lim = 0;
        while (BUSY !== 1'b1 && lim < 10) begin
            @(negedge CLK);
            lim++;
        end
        chk("busok start", (lim < 10), 1);
        REQ = 0;
        serve("busok", 1, 1, 0, 0, 99);

        for (int i = 0; i < 25; i++) begin
            logic rw, size, a0;
            int d, b;
            rw   = 1'($urandom);
            size = 1'($urandom);
            a0   = 1'($urandom);
            d    = $urandom_range(0, 9);
            b    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 99;
            txn($sformatf("rnd%0d", i), rw, size, a0, d, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
